spike_network: RTL and testbench
================================

# spike_network

Broadcast side of the neuron spike exchange. Each round, it collects the 2-bit `spike_out` codes from all `NUM_NEURON` neuron instances once every neuron raises `en_network`. It then selects exactly one firing neuron by round-robin scan and broadcasts `{code, id}` on the shared `spike_in` bus with a `networkDone` handshake. It sits between the neuron array and the top-level controller, and it is the only driver of `spike_in` and `networkDone`.

## Interface
- `TEN_DATA_WIDTH`, 2: spike code width; fixed at 2.
- `NUM_NEURON`, 512: number of neurons; need not be a power of 2.
- `NEURON_ID_WIDTH`, 9: neuron index width; must satisfy 2^`NEURON_ID_WIDTH` >= `NUM_NEURON`.
- `clk` input 1: single clock; everything here is clocked on its rising edge.
- `reset_l` input 1: asynchronous, active-low reset.
- `en_network` input `NUM_NEURON`: request bit `i` comes from neuron `i`.
- `spike_vec` input `TEN_DATA_WIDTH*NUM_NEURON`: bits `[2i+1:2i]` carry neuron `i`'s `spike_out`.
  - 0 = none, 1 = positive, 2 = negative, 3 = illegal.
- `spike_in` output `TEN_DATA_WIDTH+NEURON_ID_WIDTH`: broadcast `{code[1:0], id}` to all neurons.
- `networkDone` output 1: round complete; fanned out to all neurons.
- `busy` output 1: high in SCAN and DONE.
- `round_cnt` output 16: number of completed rounds; wraps at 0xFFFF -> 0.

## Operation
- States: IDLE, SCAN, DONE.
- Internal state:
  - `snap` (2*`NUM_NEURON` bits)
  - `idx`, `rr_ptr` (`NEURON_ID_WIDTH` bits each)
  - `scan_cnt` (`NEURON_ID_WIDTH`+1 bits)
- IDLE:
  - If `&en_network`: load `snap <= spike_vec`, `idx <= rr_ptr`, `scan_cnt <= 0`, go to SCAN.
  - A partial set of requests is ignored; the block waits indefinitely.
- SCAN: examine `c = snap[2*idx+1:2*idx]`, one neuron per cycle.
  - If `c` is 1 or 2: `spike_in <= {c, idx}`, `rr_ptr <= idx+1` (wrapping `NUM_NEURON-1` -> 0), `round_cnt++`, go to DONE.
  - Else, if `scan_cnt == NUM_NEURON-1`: no neuron fired. `spike_in <= 0`, `rr_ptr` unchanged, `round_cnt++`, go to DONE.
  - Otherwise: `idx <= idx+1` with the same wrap, `scan_cnt++`.
- Code 3 is treated as no spike and is never broadcast.
- DONE:
  - `networkDone = 1`.
  - When `|en_network == 0`, go to IDLE.
  - Partial deassertion keeps the block in DONE.
- `spike_in` holds its value from entry to DONE until the next SCAN hit or no-spike result. Neurons sample it one cycle after `networkDone`, so it must not change in IDLE.
- `networkDone` and `busy` are decoded from registered state only; there is no combinational path from inputs to outputs.
- `spike_vec` changes after the snapshot do not affect the current round.

## Timing
- Reset (async, any state): state = IDLE, `spike_in = 0`, `networkDone = 0`, `busy = 0`, `round_cnt = 0`, `rr_ptr = 0`, `snap = 0`.
- Reset mid-SCAN or mid-DONE aborts the round and produces no broadcast.
- Capture edge E0 is the edge where `&en_network` is seen in IDLE.
- If the winner is at round-robin distance `k` from `rr_ptr`, `networkDone` rises after edge E(k+1).
- If no neuron fired, `networkDone` rises after edge E(`NUM_NEURON`).
- `networkDone` stays high while any `en_network` bit is high. It falls on the edge after all bits are low, with the return to IDLE.
- A new capture can occur at the earliest one cycle after the return to IDLE.
- Worst-case round latency: `NUM_NEURON`+1 cycles plus the handshake release.

## Test plan
- Single spike, `NUM_NEURON = 8`, `rr_ptr = 0`, neuron 5 code 1, all `en_network` high:
  - `networkDone` rises after E6 with `spike_in = {2'b01, 9'd5}`.
  - Afterwards `rr_ptr = 6` and `round_cnt = 1`.
- Round-robin fairness: neurons 2 and 6 both code 2 every round.
  - Successive rounds broadcast id 2, then 6, then 2.
  - The second round's latency corresponds to distance 3 from `rr_ptr = 3`.
- No spike / illegal code, all codes 0 except neuron 4 = 3:
  - `spike_in = 0`, `networkDone` after E8, `rr_ptr` unchanged, `round_cnt` incremented.
- Wrap-around: `rr_ptr = 7`, only neuron 1 fires.
  - Scan order is 7, 0, 1; done after E3, id = 1, `rr_ptr = 2`.
- Handshake:
  - 7 of 8 `en_network` bits high: the block stays in IDLE.
  - In DONE, release 4 bits, then the rest 3 cycles later: `networkDone` stays high until the cycle after the final release.
  - `spike_in` stays stable through the following IDLE.
- Reset mid-SCAN:
  - Assert `reset_l = 0` asynchronously between edges: all outputs go to 0 immediately.
  - After release, a new round starts from `rr_ptr = 0`.

Source files
------------

// File: rtl/spike_network.sv
// spike_network
// Broadcast side of the neuron spike exchange. Once every neuron raises its
// en_network request, the current spike codes are snapshotted and scanned
// round-robin, one neuron per cycle, starting at rr_ptr. The first neuron
// holding a positive (1) or negative (2) code wins, and {code, id} is placed
// on spike_in. networkDone then holds until every request bit has dropped.
// Code 3 is illegal and is treated as "no spike".
// spike_in is held from the DONE entry through the following IDLE, because
// neurons sample it one cycle after networkDone.

module spike_network #(
  parameter int TEN_DATA_WIDTH  = 2,
  parameter int NUM_NEURON      = 512,
  parameter int NEURON_ID_WIDTH = 9
) (
  input  logic                                  clk,
  input  logic                                  reset_l,
  input  logic [NUM_NEURON-1:0]                 en_network,
  input  logic [TEN_DATA_WIDTH*NUM_NEURON-1:0]  spike_vec,
  output logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_in,
  output logic                                  networkDone,
  output logic                                  busy,
  output logic [15:0]                           round_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int SNAP_W = TEN_DATA_WIDTH * NUM_NEURON;
  localparam int OUT_W  = TEN_DATA_WIDTH + NEURON_ID_WIDTH;

  localparam logic [NEURON_ID_WIDTH-1:0] LAST_ID  = NEURON_ID_WIDTH'(NUM_NEURON - 1);
  localparam logic [NEURON_ID_WIDTH:0]   LAST_CNT = (NEURON_ID_WIDTH + 1)'(NUM_NEURON - 1);

  // Advance a neuron index, wrapping the last neuron back to 0. The wrap
  // matters when NUM_NEURON is not a power of two.
  function automatic logic [NEURON_ID_WIDTH-1:0] next_id(input logic [NEURON_ID_WIDTH-1:0] id);
    logic [NEURON_ID_WIDTH-1:0] nxt;
    if (id == LAST_ID) begin
      nxt = {NEURON_ID_WIDTH{1'b0}};
    end else begin
      nxt = id + {{(NEURON_ID_WIDTH-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

  // A code fires only when it is positive (01) or negative (10).
  // Code 11 is illegal and is ignored like 00.
  function automatic logic code_fires(input logic [1:0] code);
    return (code == 2'b01) || (code == 2'b10);
  endfunction

  logic [1:0]                 state_r;
  logic [SNAP_W-1:0]          snap_r;
  logic [NEURON_ID_WIDTH-1:0] idx_r;
  logic [NEURON_ID_WIDTH-1:0] rr_ptr_r;
  logic [NEURON_ID_WIDTH:0]   scan_cnt_r;
  logic [OUT_W-1:0]           spike_in_r;
  logic [15:0]                round_cnt_r;

  logic [1:0]                 code_s;
  logic                       en_all_s;
  logic                       en_any_s;

  // Request reductions: all bits start a round, no bits end the handshake.
  always_comb begin
    en_all_s = &en_network;
    en_any_s = |en_network;
  end

  // Select the snapshot code of the neuron currently under the scan pointer
  // (AND-OR multiplexer over all neurons).
  always_comb begin
    code_s = 2'b00;
    for (int i = 0; i < NUM_NEURON; i++) begin
      code_s = code_s | ({2{idx_r == NEURON_ID_WIDTH'(i)}} & snap_r[2*i +: 2]);
    end
  end

  // Round controller: capture in IDLE, one-neuron-per-cycle scan, then hold
  // DONE until every request bit has been released.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_r     <= ST_IDLE;
      snap_r      <= {SNAP_W{1'b0}};
      idx_r       <= {NEURON_ID_WIDTH{1'b0}};
      rr_ptr_r    <= {NEURON_ID_WIDTH{1'b0}};
      scan_cnt_r  <= {(NEURON_ID_WIDTH+1){1'b0}};
      spike_in_r  <= {OUT_W{1'b0}};
      round_cnt_r <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A partial request set is ignored; wait for every neuron.
          if (en_all_s) begin
            snap_r     <= spike_vec;
            idx_r      <= rr_ptr_r;
            scan_cnt_r <= {(NEURON_ID_WIDTH+1){1'b0}};
            state_r    <= ST_SCAN;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (code_fires(code_s)) begin
            spike_in_r  <= {code_s, idx_r};
            rr_ptr_r    <= next_id(idx_r);
            round_cnt_r <= round_cnt_r + 16'd1;
            state_r     <= ST_DONE;
          end else if (scan_cnt_r == LAST_CNT) begin
            // Full lap without a winner: broadcast "nothing", keep pointer.
            spike_in_r  <= {OUT_W{1'b0}};
            round_cnt_r <= round_cnt_r + 16'd1;
            state_r     <= ST_DONE;
          end else begin
            idx_r       <= next_id(idx_r);
            scan_cnt_r  <= scan_cnt_r + {{NEURON_ID_WIDTH{1'b0}}, 1'b1};
            state_r     <= ST_SCAN;
          end
        end
        ST_DONE: begin
          // Partial release keeps the handshake asserted.
          if (!en_any_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers or from a decode of the state
  // register, so no input reaches an output combinationally.
  assign spike_in    = spike_in_r;
  assign round_cnt   = round_cnt_r;
  assign networkDone = (state_r == ST_DONE);
  assign busy        = (state_r == ST_SCAN) || (state_r == ST_DONE);

endmodule

// File: tb/tb_spike_network.sv
// Scoreboard bench for spike_network with 8 neurons. Each round pushes its
// expected broadcast, round count and capture-to-done latency. A negedge
// monitor pops and compares these on every rising networkDone.

module tb_spike_network;

  localparam int NN  = 8;
  localparam int IDW = 9;
  localparam int TW  = 2;

  logic                 clk = 1'b0;
  logic                 reset_l;
  logic [NN-1:0]        en_network;
  logic [TW*NN-1:0]     spike_vec;
  logic [TW+IDW-1:0]    spike_in;
  logic                 networkDone;
  logic                 busy;
  logic [15:0]          round_cnt;

  typedef struct {
    logic [10:0] si;
    logic [15:0] rc;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;

  spike_network #(
    .TEN_DATA_WIDTH (TW),
    .NUM_NEURON     (NN),
    .NEURON_ID_WIDTH(IDW)
  ) dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .en_network (en_network),
    .spike_vec  (spike_vec),
    .spike_in   (spike_in),
    .networkDone(networkDone),
    .busy       (busy),
    .round_cnt  (round_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: note when a round starts (busy rises), and on every rising
  // networkDone compare the outputs against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (busy && !prev_busy) start_cyc = cyc;
    if (networkDone && !prev_done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("spike_in", 32'(spike_in), 32'(e.si));
        check("round_cnt", 32'(round_cnt), 32'(e.rc));
        check("latency", 32'(cyc - start_cyc), 32'(e.lat));
      end
    end
    prev_busy = busy;
    prev_done = networkDone;
  end

  // One full round. After capture, spike_vec is scrambled to show that the
  // snapshot is used. With partial set, the bench releases half the
  // requests, holds 3 cycles, then releases the rest and watches IDLE.
  task automatic run_round(input logic [15:0] vec, input logic [1:0] code,
                           input logic [8:0] id, input logic [15:0] rc,
                           input int lat, input bit partial);
    exp_t e;
    int   t;
    e.si = {code, id};
    e.rc = rc;
    e.lat = lat;
    sb_q.push_back(e);
    @(negedge clk);
    spike_vec  = vec;
    en_network = 8'hFF;
    @(negedge clk);
    spike_vec  = 16'h5555;
    t = 0;
    while (!networkDone && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!networkDone) check("done_timeout", 32'd0, 32'd1);
    if (partial) begin
      en_network = 8'h0F;
      repeat (3) begin
        @(negedge clk);
        check("done_hold_partial", 32'(networkDone), 32'd1);
      end
      en_network = 8'h00;
      @(negedge clk);
      check("done_fall", 32'(networkDone), 32'd0);
      repeat (3) begin
        @(negedge clk);
        check("spike_in_idle_hold", 32'(spike_in), 32'({code, id}));
        check("busy_idle", 32'(busy), 32'd0);
      end
    end else begin
      en_network = 8'h00;
      t = 0;
      while (networkDone && t < 10) begin
        @(negedge clk);
        t++;
      end
      check("done_release", 32'(networkDone), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_l    = 1'b1;
    en_network = 8'h00;
    spike_vec  = 16'h0000;
    #1 reset_l = 1'b0;
    #2;
    check("rst_spike_in", 32'(spike_in), 32'd0);
    check("rst_done", 32'(networkDone), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_round_cnt", 32'(round_cnt), 32'd0);
    repeat (2) @(negedge clk);
    reset_l = 1'b1;

    // 7 of 8 requests: must stay idle.
    @(negedge clk);
    spike_vec  = 16'h2020;
    en_network = 8'h7F;
    repeat (4) begin
      @(negedge clk);
      check("partial_req_busy", 32'(busy), 32'd0);
      check("partial_req_done", 32'(networkDone), 32'd0);
    end
    en_network = 8'h00;

    // Fairness: neurons 2 and 6 code 2 each round.
    run_round(16'h2020, 2'b10, 9'd2, 16'd1, 3, 1'b0); // rr 0 -> 3
    run_round(16'h2020, 2'b10, 9'd6, 16'd2, 4, 1'b0); // rr 3, dist 3 -> 7
    run_round(16'h2020, 2'b10, 9'd2, 16'd3, 4, 1'b0); // rr 7: 7,0,1,2 -> 3
    // Neuron 6 only, partial handshake release.
    run_round(16'h1000, 2'b01, 9'd6, 16'd4, 4, 1'b1); // rr 3 -> 7
    // Wrap-around: scan 7,0,1.
    run_round(16'h0004, 2'b01, 9'd1, 16'd5, 3, 1'b0); // rr 7 -> 2
    // No spike, neuron 4 illegal code 3: full lap, rr unchanged.
    run_round(16'h0300, 2'b00, 9'd0, 16'd6, 8, 1'b0); // rr stays 2
    // rr must still be 2: neuron 2 wins over neuron 1.
    run_round(16'h0024, 2'b10, 9'd2, 16'd7, 1, 1'b0); // rr 2 -> 3

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    spike_vec  = 16'h4000;
    en_network = 8'hFF;
    @(negedge clk);
    check("midscan_busy", 32'(busy), 32'd1);
    #2 reset_l = 1'b0;
    #1;
    check("midrst_spike_in", 32'(spike_in), 32'd0);
    check("midrst_done", 32'(networkDone), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_round_cnt", 32'(round_cnt), 32'd0);
    en_network = 8'h00;
    @(negedge clk);
    reset_l = 1'b1;

    // Single spike, neuron 5 from rr 0, then verify rr = 6.
    run_round(16'h0400, 2'b01, 9'd5, 16'd1, 6, 1'b0); // rr 0 -> 6
    run_round(16'h4400, 2'b01, 9'd7, 16'd2, 2, 1'b0); // rr 6: 6,7

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
